// File: rtl/sokoban_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_ctrl_if
// Brief    : Command and map-RAM bus between a move requester and the
//            sokoban move controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sokoban_move_ctrl_if #(
    parameter int CELL_W = 2
);
    logic              cmd_valid;
    logic [1:0]        cmd_dir;
    logic              cmd_ready;
    logic [5:0]        map_raddr;
    logic              map_re;
    logic [CELL_W-1:0] map_rdata;
    logic              map_we;
    logic [5:0]        map_waddr;
    logic [CELL_W-1:0] map_wdata;
    logic [5:0]        man;
    logic              done;
    logic [1:0]        result;

    // Requester / map RAM side
    modport master (
        output cmd_valid, cmd_dir, map_rdata,
        input  cmd_ready, map_raddr, map_re, map_we, map_waddr, map_wdata,
               man, done, result
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_dir, map_rdata,
        output cmd_ready, map_raddr, map_re, map_we, map_waddr, map_wdata,
               man, done, result
    );
endinterface
`default_nettype wire

// File: rtl/sokoban_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_ctrl
// Brief    : Sequences one player move per command on an 8x8 board: reads the
//            target (and beyond-box) cells, decides move/push/blocked, writes
//            back the box relocation and owns the man position.
//            Optional macro MOVE_COUNT_EN adds a saturating move_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module sokoban_move_ctrl #(
    parameter logic [5:0] START_POS = 6'd9,
    parameter int         CELL_W    = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    sokoban_move_ctrl_if.slave   bus
`ifdef MOVE_COUNT_EN
    ,
    output logic [9:0]           move_cnt
`endif
);

    localparam logic [3:0] c_S_IDLE   = 4'd0;
    localparam logic [3:0] c_S_RD1    = 4'd1;
    localparam logic [3:0] c_S_W1     = 4'd2;
    localparam logic [3:0] c_S_RD2    = 4'd3;
    localparam logic [3:0] c_S_W2     = 4'd4;
    localparam logic [3:0] c_S_WR_BOX = 4'd5;
    localparam logic [3:0] c_S_WR_CLR = 4'd6;
    localparam logic [3:0] c_S_COMMIT = 4'd7;
    localparam logic [3:0] c_S_FINISH = 4'd8;

    localparam logic [CELL_W-1:0] c_CELL_FLOOR = CELL_W'(0);
    localparam logic [CELL_W-1:0] c_CELL_BOX   = CELL_W'(2);

    localparam logic [1:0] c_RES_MOVED   = 2'd0;
    localparam logic [1:0] c_RES_PUSHED  = 2'd1;
    localparam logic [1:0] c_RES_BLOCKED = 2'd2;

    logic [3:0]        r_state;
    logic [1:0]        r_dir;
    logic [5:0]        r_t;
    logic [5:0]        r_man;
    logic [5:0]        r_map_raddr;
    logic              r_map_re;
    logic              r_map_we;
    logic [5:0]        r_map_waddr;
    logic [CELL_W-1:0] r_map_wdata;
    logic              r_done;
    logic [1:0]        r_result;

    logic [6:0]        w_nb_man;
    logic [6:0]        w_nb_t;

    // Returns {valid, row, col}; rows and cols step independently so an edge
    // crossing is flagged instead of wrapping into the neighbouring field.
    function automatic logic [6:0] f_nb(input logic [5:0] p, input logic [1:0] d);
        logic [2:0] row;
        logic [2:0] col;
        logic       ok;
        row = p[5:3];
        col = p[2:0];
        ok  = 1'b1;
        case (d)
            2'd0: if (row == 3'd0) ok = 1'b0; else row = row - 3'd1;
            2'd1: if (row == 3'd7) ok = 1'b0; else row = row + 3'd1;
            2'd2: if (col == 3'd0) ok = 1'b0; else col = col - 3'd1;
            default: if (col == 3'd7) ok = 1'b0; else col = col + 3'd1;
        endcase
        return {ok, row, col};
    endfunction

    assign w_nb_man = f_nb(r_man, bus.cmd_dir);
    assign w_nb_t   = f_nb(r_t, r_dir);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_dir       <= 2'd0;
            r_t         <= 6'd0;
            r_man       <= START_POS;
            r_map_raddr <= 6'd0;
            r_map_re    <= 1'b0;
            r_map_we    <= 1'b0;
            r_map_waddr <= 6'd0;
            r_map_wdata <= c_CELL_FLOOR;
            r_done      <= 1'b0;
            r_result    <= c_RES_MOVED;
        end else begin
            // Strobes are set only on the transition into their state.
            r_map_re <= 1'b0;
            r_map_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_dir <= bus.cmd_dir;
                        r_t   <= w_nb_man[5:0];
                        if (!w_nb_man[6]) begin
                            r_result <= c_RES_BLOCKED;
                            r_done   <= 1'b1;
                            r_state  <= c_S_FINISH;
                        end else begin
                            r_map_re    <= 1'b1;
                            r_map_raddr <= w_nb_man[5:0];
                            r_state     <= c_S_RD1;
                        end
                    end
                end
                c_S_RD1: r_state <= c_S_W1;
                c_S_W1: begin
                    if (bus.map_rdata == c_CELL_FLOOR) begin
                        r_result <= c_RES_MOVED;
                        r_state  <= c_S_COMMIT;
                    end else if (bus.map_rdata == c_CELL_BOX && w_nb_t[6]) begin
                        r_map_re    <= 1'b1;
                        r_map_raddr <= w_nb_t[5:0];
                        r_state     <= c_S_RD2;
                    end else begin
                        r_result <= c_RES_BLOCKED;
                        r_done   <= 1'b1;
                        r_state  <= c_S_FINISH;
                    end
                end
                c_S_RD2: r_state <= c_S_W2;
                c_S_W2: begin
                    if (bus.map_rdata == c_CELL_FLOOR) begin
                        r_map_we    <= 1'b1;
                        r_map_waddr <= r_map_raddr;
                        r_map_wdata <= c_CELL_BOX;
                        r_state     <= c_S_WR_BOX;
                    end else begin
                        r_result <= c_RES_BLOCKED;
                        r_done   <= 1'b1;
                        r_state  <= c_S_FINISH;
                    end
                end
                c_S_WR_BOX: begin
                    r_map_we    <= 1'b1;
                    r_map_waddr <= r_t;
                    r_map_wdata <= c_CELL_FLOOR;
                    r_state     <= c_S_WR_CLR;
                end
                c_S_WR_CLR: begin
                    r_result <= c_RES_PUSHED;
                    r_state  <= c_S_COMMIT;
                end
                c_S_COMMIT: begin
                    r_man   <= r_t;
                    r_done  <= 1'b1;
                    r_state <= c_S_FINISH;
                end
                c_S_FINISH: r_state <= c_S_IDLE;
                default:    r_state <= c_S_IDLE;
            endcase
        end
    end

`ifdef MOVE_COUNT_EN
    logic [9:0] r_move_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_move_cnt <= 10'd0;
        end else if (r_state == c_S_COMMIT && r_move_cnt != 10'd1023) begin
            r_move_cnt <= r_move_cnt + 10'd1;
        end
    end

    assign move_cnt = r_move_cnt;
`endif

    assign bus.cmd_ready = (r_state == c_S_IDLE);
    assign bus.map_raddr = r_map_raddr;
    assign bus.map_re    = r_map_re;
    assign bus.map_we    = r_map_we;
    assign bus.map_waddr = r_map_waddr;
    assign bus.map_wdata = r_map_wdata;
    assign bus.man       = r_man;
    assign bus.done      = r_done;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sokoban_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sokoban_move_ctrl
// Brief    : Scoreboard bench for sokoban_move_ctrl with a behavioural map RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sokoban_move_ctrl;

    typedef struct {
        int res;
        int man;
        int lat;
        int cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   acc_cyc;
    int   n_cmp;
    int   n_fail;
    int   exp_cnt;

    exp_t exp_q[$];
    int   rd_q[$];
    int   wr_q[$];

    logic [1:0] mem [64];

    sokoban_move_ctrl_if #(.CELL_W(2)) u_if ();

`ifdef MOVE_COUNT_EN
    logic [9:0] move_cnt;
`endif

    sokoban_move_ctrl #(
        .START_POS (6'd9),
        .CELL_W    (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (u_if.slave)
`ifdef MOVE_COUNT_EN
        ,
        .move_cnt (move_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Map RAM: one-cycle read latency
    always @(posedge clk) begin
        if (u_if.map_re) u_if.map_rdata <= mem[u_if.map_raddr];
        if (u_if.map_we) mem[u_if.map_waddr] = u_if.map_wdata;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT output event against the queued expectations
    always @(negedge clk) begin
        exp_t e;
        int   w;
        if (u_if.map_re === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected_read", 1, 0);
            else check("read_addr", int'(u_if.map_raddr), rd_q.pop_front());
            if (u_if.map_we === 1'b1) check("re_we_overlap", 1, 0);
        end
        if (u_if.map_we === 1'b1) begin
            if (wr_q.size() == 0) check("unexpected_write", int'(u_if.map_waddr), -1);
            else begin
                w = wr_q.pop_front();
                check("write_addr", int'(u_if.map_waddr), w / 4);
                check("write_data", int'(u_if.map_wdata), w % 4);
            end
        end
        if (u_if.done === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("result", int'(u_if.result), e.res);
                check("man", int'(u_if.man), e.man);
                check("latency", cyc - acc_cyc, e.lat);
                check("ready_in_finish", int'(u_if.cmd_ready), 0);
`ifdef MOVE_COUNT_EN
                check("move_cnt", int'(move_cnt), e.cnt);
`endif
            end
        end
    end

    task automatic exp_rd(input int a);
        rd_q.push_back(a);
    endtask

    task automatic exp_wr(input int a, input int d);
        wr_q.push_back(a * 4 + d);
    endtask

    task automatic accept(input logic [1:0] dir);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (u_if.cmd_ready === 1'b1) break;
        end
        if (k == 50) check("ready_timeout", 0, 1);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_dir   = dir;
        acc_cyc        = cyc;
        @(posedge clk);
        #1;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_dir   = ~dir;
    endtask

    task automatic issue(input logic [1:0] dir, input int res, input int man, input int lat);
        exp_t e;
        int   k;
        if (res != 2) exp_cnt++;
        e.res = res;
        e.man = man;
        e.lat = lat;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        accept(dir);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (k == 40) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_man"}, int'(u_if.man), 9);
        check({tag, "_ready"}, int'(u_if.cmd_ready), 1);
        check({tag, "_done"}, int'(u_if.done), 0);
        check({tag, "_re"}, int'(u_if.map_re), 0);
        check({tag, "_we"}, int'(u_if.map_we), 0);
        check({tag, "_result"}, int'(u_if.result), 0);
        check({tag, "_waddr"}, int'(u_if.map_waddr), 0);
`ifdef MOVE_COUNT_EN
        check({tag, "_move_cnt"}, int'(move_cnt), 0);
`endif
    endtask

    initial begin
        int k;
        n_cmp   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        cyc     = 0;
        acc_cyc = 0;
        for (int i = 0; i < 64; i++) mem[i] = 2'd0;
        mem[1]  = 2'd1;
        mem[8]  = 2'd3;
        mem[11] = 2'd2;
        mem[13] = 2'd2;
        mem[15] = 2'd2;
        rst_n          = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_dir   = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_raddr", int'(u_if.map_raddr), 0);
        check("reset_wdata", int'(u_if.map_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset("reset");

        exp_rd(1);                       issue(2'd0, 2, 9, 3);   // wall above
        exp_rd(10);                      issue(2'd3, 0, 10, 4);  // plain move
        exp_rd(11); exp_rd(12);
        exp_wr(12, 2); exp_wr(11, 0);    issue(2'd3, 1, 11, 8);  // push
        exp_rd(12); exp_rd(13);          issue(2'd3, 2, 11, 5);  // box behind box
        exp_rd(3);                       issue(2'd0, 0, 3, 4);
        for (int c = 4; c <= 7; c++) begin
            exp_rd(c);                   issue(2'd3, 0, c, 4);
        end
        issue(2'd3, 2, 7, 1);                                    // right edge
        issue(2'd0, 2, 7, 1);                                    // top edge
        exp_rd(15); exp_rd(23);
        exp_wr(23, 2); exp_wr(15, 0);    issue(2'd1, 1, 15, 8);  // push down

        // Abort a push right after its box write
        exp_rd(23); exp_rd(31); exp_wr(31, 2);
        accept(2'd1);
        for (k = 0; k < 20; k++) begin
            if (u_if.map_we === 1'b1 && u_if.map_wdata == 2'd2) break;
            @(negedge clk);
        end
        if (k == 20) check("box_write_timeout", 0, 1);
        rst_n   = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check("abort_no_clear", int'(u_if.map_we), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset("abort");
        check("abort_box_kept", int'(mem[23]), 2);

        exp_rd(8);                       issue(2'd2, 2, 9, 3);   // reserved cell
        exp_rd(17);                      issue(2'd1, 0, 17, 4);

        repeat (3) @(negedge clk);
        check("rd_queue_empty", rd_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);
        check("map_11_cleared", int'(mem[11]), 0);
        check("map_12_box", int'(mem[12]), 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sokoban_move_ctrl.md
Name: sokoban_move_ctrl

Overview:
- Sequences one player move per command on the 8x8 board of 64x64 tiles.
- On each command it reads the target cell from the external map RAM and, if the move is a push, the cell beyond it.
- It decides whether the move is a plain move, a box push or blocked, then writes back the box relocation.
- It owns the 6-bit man position {row[2:0], col[2:0]} that feeds the man sprite layer's man input.

Parameters:
START_POS, 6'd9, man position after reset (row 1, col 1)
CELL_W, 2, width of a map cell code

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  move request valid
cmd_dir  in  2  0=up (row-1), 1=down (row+1), 2=left (col-1), 3=right (col+1)
cmd_ready  out  1  high only in IDLE
map_raddr  out  6  map RAM read address {row,col}
map_re  out  1  read enable; map_rdata is valid exactly 1 cycle after map_re
map_rdata  in  2  cell code: 0=floor, 1=wall, 2=box, 3=reserved (treated as wall)
map_we  out  1  single-cycle write strobe
map_waddr  out  6  write address
map_wdata  out  2  write data
man  out  6  current man position
done  out  1  1-cycle pulse when a command completes
result  out  2  valid with done: 0=moved, 1=pushed, 2=blocked, 3=unused

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, man=START_POS.
  - done, map_re and map_we are 0.
  - map_raddr, map_waddr, map_wdata and result are 0.
  - Reset mid-command aborts it with no further writes. Map consistency after an aborted push is the map loader's responsibility.
- Neighbour function nb(p,d):
  - Computed on the row/col fields separately; no 6-bit carry between fields.
  - Invalid if it would leave rows/cols 0..7: up at row 0, down at row 7, left at col 0, right at col 7.
- IDLE:
  - cmd_ready=1. On cmd_valid&&cmd_ready, latch dir and T=nb(man,dir).
  - If T is invalid, go to FINISH with result=2 and issue no RAM read.
  - Otherwise go to RD1.
- RD1: map_re=1, map_raddr=T -> W1.
- W1: evaluate map_rdata (cell at T).
  - floor -> COMMIT with result=0.
  - wall or reserved -> FINISH with result=2.
  - box -> compute B=nb(T,dir). If B is invalid -> FINISH with result=2; else -> RD2.
- RD2: map_re=1, map_raddr=B -> W2.
- W2: evaluate cell at B.
  - floor -> WR_BOX.
  - anything else -> FINISH with result=2.
- WR_BOX: map_we=1, waddr=B, wdata=2 -> WR_CLR.
- WR_CLR: map_we=1, waddr=T, wdata=0 -> COMMIT with result=1.
- COMMIT: man<=T -> FINISH.
- FINISH: done=1 for one cycle, result held stable -> IDLE.
- Timing and ordering:
  - cmd_ready is 0 during FINISH, so the earliest next acceptance is the cycle after done.
  - Latency from acceptance to done: blocked at edge 1 cycle; plain move 4 cycles; push 8 cycles.
  - man changes only in COMMIT.
  - At most one map_we per cycle; map_re and map_we are never high in the same cycle.
  - The box write always precedes the clear.
- cmd_dir is sampled only at acceptance; changes to it during a command are ignored.
- cmd_valid held high after done starts a new command; no auto-repeat beyond that.

Optional Feature:
- MOVE_COUNT_EN:
  - Defined: adds output move_cnt[9:0].
  - Reset to 0; increments by 1 in COMMIT (result 0 or 1 only).
  - Saturates at 10'd1023; blocked moves never count.
- Undefined: no move_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then man=9. cmd_dir=3, T=10 reads floor -> one map_re at addr 10, no map_we, done with result=0, man=10 four cycles after acceptance.
- man=9, cmd_dir=0, cell 1 reads wall -> result=2, man stays 9, no map_we.
- man=10, cmd_dir=3: cell 11=box, cell 12=floor.
  - Expect reads at 11 then 12, writes (12,2) then (11,0).
  - Expect result=1 and man=11 eight cycles after acceptance.
- man=11, cmd_dir=3: cell 12=box, cell 13=box -> result=2, no writes, man=11.
- man=7 (row 0, col 7) with dir=3 and with dir=0 -> result=2 with zero map_re, done one cycle after acceptance. Box at 15 pushed down from man=7 with row of B=2 valid -> push succeeds.
- Assert rst_n=0 in the cycle after WR_BOX -> no WR_CLR write, man=START_POS, cmd_ready=1 the cycle after release. With MOVE_COUNT_EN, move_cnt returns to 0 after reset and does not change on blocked moves.
